// File: rtl/gerenciador_alarme_pkg.sv
// gerenciador_alarme_pkg
// Shared plant definitions for the alarm manager and the supervisory panel logic:
// FSM state codes, parameter defaults and a saturating event-counter helper.
package gerenciador_alarme_pkg;

  typedef enum logic [2:0] {
    StNormal      = 3'd0,
    StSuspeita    = 3'd1,
    StAlarme      = 3'd2,
    StReconhecido = 3'd3,
    StRetorno     = 3'd4
  } estado_e;

  localparam int unsigned FiltroPadrao        = 4;
  localparam int unsigned MeioPeriodoPadrao   = 8;
  localparam int unsigned EsperaRetornoPadrao = 8;

  // Event counter sticks at 255 rather than wrapping.
  function automatic logic [7:0] incr_sat8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gerenciador_alarme_if.sv
// gerenciador_alarme_if
// Signal bundle between the plant/operator side and the alarm manager.
//   alarmeSonoroSC : raw alarm from the comparator stage (may glitch)
//   reconhecer     : operator acknowledge, level
//   teste          : lamp/siren test request, level
//   sirene         : siren drive
//   lampada        : alarm lamp
//   estado         : current FSM state code
//   eventos        : saturating count of alarm declarations
// master = plant/operator side, slave = gerenciador_alarme.
interface gerenciador_alarme_if;

  logic       alarmeSonoroSC;
  logic       reconhecer;
  logic       teste;
  logic       sirene;
  logic       lampada;
  logic [2:0] estado;
  logic [7:0] eventos;

  modport master (
    output alarmeSonoroSC,
    output reconhecer,
    output teste,
    input  sirene,
    input  lampada,
    input  estado,
    input  eventos
  );

  modport slave (
    input  alarmeSonoroSC,
    input  reconhecer,
    input  teste,
    output sirene,
    output lampada,
    output estado,
    output eventos
  );

endinterface

// File: rtl/gerador_sirene.sv
// gerador_sirene
// Siren pattern generator: half-period counter with a registered toggle output.
//   clock, reset : sole clock, synchronous active-high reset
//   clr          : restart the pattern; output is 1 for the next MEIO_PERIODO cycles
//   en           : advance the pattern (held while the alarm persists)
//   forca        : value driven on the output while neither clr nor en is active
//   tom          : registered siren drive
module gerador_sirene #(
  parameter int unsigned MEIO_PERIODO = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic forca,
  output logic tom
);

  localparam int unsigned W = (MEIO_PERIODO > 1) ? $clog2(MEIO_PERIODO) : 1;
  localparam logic [W-1:0] Fim = W'(MEIO_PERIODO - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tom_q, tom_d;

  always_comb begin
    cnt_d = cnt_q;
    tom_d = tom_q;
    if (clr) begin
      // The entry cycle already counts as the first cycle of the "on" half.
      cnt_d = '0;
      tom_d = 1'b1;
    end else if (en) begin
      if (cnt_q == Fim) begin
        cnt_d = '0;
        tom_d = ~tom_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = '0;
      tom_d = forca;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tom_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tom_q <= tom_d;
    end
  end

  assign tom = tom_q;

endmodule

// File: rtl/gerenciador_alarme.sv
// gerenciador_alarme
// Alarm manager: filters the raw alarm input, latches alarms until acknowledged,
// waits for a stable quiet period before returning to normal, drives siren and lamp,
// and counts alarm declarations.
//   clock, reset : sole clock (rising edge), synchronous active-high reset
//   bus          : gerenciador_alarme_if.slave (inputs alarmeSonoroSC, reconhecer, teste;
//                  registered outputs sirene, lampada, estado, eventos)
module gerenciador_alarme
  import gerenciador_alarme_pkg::*;
#(
  parameter int unsigned FILTRO         = FiltroPadrao,
  parameter int unsigned MEIO_PERIODO   = MeioPeriodoPadrao,
  parameter int unsigned ESPERA_RETORNO = EsperaRetornoPadrao
) (
  input logic                 clock,
  input logic                 reset,
  gerenciador_alarme_if.slave bus
);

  localparam logic [7:0] FimFiltro  = 8'(FILTRO - 1);
  localparam logic [7:0] FimRetorno = 8'(ESPERA_RETORNO);

  estado_e    estado_q, estado_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] eventos_q, eventos_d;
  logic       lampada_q, lampada_d;
  logic       entra_alarme;
  logic       fica_alarme;
  logic       modo_teste;
  logic       tom;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    case (estado_q)
      StNormal: begin
        if (bus.alarmeSonoroSC) begin
          estado_d = StSuspeita;
          cnt_d    = 8'd1;
        end else begin
          cnt_d = '0;
        end
      end
      StSuspeita: begin
        if (!bus.alarmeSonoroSC) begin
          estado_d = StNormal;
          cnt_d    = '0;
        end else if (cnt_q == FimFiltro) begin
          estado_d = StAlarme;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAlarme: begin
        // Latched: only the acknowledge leaves this state.
        cnt_d = '0;
        if (bus.reconhecer) begin
          estado_d = StReconhecido;
        end
      end
      StReconhecido: begin
        if (!bus.alarmeSonoroSC) begin
          estado_d = StRetorno;
          cnt_d    = 8'd1;
        end
      end
      StRetorno: begin
        // A reappearing alarm skips the filter.
        if (bus.alarmeSonoroSC) begin
          estado_d = StAlarme;
          cnt_d    = '0;
        end else if (cnt_q == FimRetorno) begin
          estado_d = StNormal;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        estado_d = StNormal;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    entra_alarme = (estado_d == StAlarme) && (estado_q != StAlarme);
    fica_alarme  = (estado_d == StAlarme) && (estado_q == StAlarme);
    // Test mode only while the FSM rests in NORMAL across the edge.
    modo_teste   = (estado_q == StNormal) && (estado_d == StNormal) && bus.teste;
    lampada_d    = (estado_d == StAlarme) || (estado_d == StReconhecido) ||
                   (estado_d == StRetorno) || modo_teste;
    eventos_d    = entra_alarme ? incr_sat8(eventos_q) : eventos_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= StNormal;
      cnt_q     <= '0;
      eventos_q <= '0;
      lampada_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      eventos_q <= eventos_d;
      lampada_q <= lampada_d;
    end
  end

  gerador_sirene #(
    .MEIO_PERIODO(MEIO_PERIODO)
  ) u_gerador_sirene (
    .clock(clock),
    .reset(reset),
    .clr  (entra_alarme),
    .en   (fica_alarme),
    .forca(modo_teste),
    .tom  (tom)
  );

  assign bus.estado  = estado_q;
  assign bus.sirene  = tom;
  assign bus.lampada = lampada_q;
  assign bus.eventos = eventos_q;

endmodule

// File: tb/tb_gerenciador_alarme.sv
// tb_gerenciador_alarme
// Directed bench for gerenciador_alarme with default parameters (FILTRO=4,
// MEIO_PERIODO=8, ESPERA_RETORNO=8). Each step drives inputs, queues the expected
// outputs after the next edge, then pops and compares them 1 time unit after that edge.
module tb_gerenciador_alarme;

  typedef struct packed {
    logic [2:0] estado;
    logic       sirene;
    logic       lampada;
    logic [7:0] eventos;
  } saida_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  saida_t     sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] ev       = 8'd0;

  gerenciador_alarme_if bus ();

  gerenciador_alarme #(
    .FILTRO        (4),
    .MEIO_PERIODO  (8),
    .ESPERA_RETORNO(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic passo(input logic rs, input logic a, input logic r, input logic t,
                       input logic [2:0] e, input logic s, input logic l,
                       input logic [7:0] v, input string tag);
    saida_t esp;
    reset              = rs;
    bus.alarmeSonoroSC = a;
    bus.reconhecer     = r;
    bus.teste          = t;
    sb.push_back('{estado: e, sirene: s, lampada: l, eventos: v});
    @(posedge clock);
    #1;
    esp = sb.pop_front();
    checks++;
    assert (bus.estado === esp.estado) else begin
      failures++;
      $error("FAIL %s estado observed=%0d expected=%0d", tag, bus.estado, esp.estado);
    end
    checks++;
    assert (bus.sirene === esp.sirene) else begin
      failures++;
      $error("FAIL %s sirene observed=%0b expected=%0b", tag, bus.sirene, esp.sirene);
    end
    checks++;
    assert (bus.lampada === esp.lampada) else begin
      failures++;
      $error("FAIL %s lampada observed=%0b expected=%0b", tag, bus.lampada, esp.lampada);
    end
    checks++;
    assert (bus.eventos === esp.eventos) else begin
      failures++;
      $error("FAIL %s eventos observed=%0d expected=%0d", tag, bus.eventos, esp.eventos);
    end
  endtask

  initial begin
    bus.alarmeSonoroSC = 1'b0;
    bus.reconhecer     = 1'b0;
    bus.teste          = 1'b0;

    // Reset state
    passo(1, 0, 0, 0, 0, 0, 0, 0, "reset");

    // Glitch rejection: 3 high samples then low
    for (int i = 0; i < 3; i++) passo(0, 1, 0, 0, 1, 0, 0, 0, "glitch");
    passo(0, 0, 0, 0, 0, 0, 0, 0, "glitch_fim");

    // Declaration after the 4th high edge, then siren pattern 8 on / 8 off / on
    for (int i = 0; i < 3; i++) passo(0, 1, 0, 0, 1, 0, 0, 0, "filtro");
    ev = 8'd1;
    passo(0, 1, 0, 0, 2, 1, 1, ev, "declara");
    for (int i = 2; i <= 17; i++) begin
      // Input drops from cycle 10 on; the alarm stays latched.
      passo(0, logic'(i < 10), 0, 0, 2, logic'(((i - 1) / 8) % 2 == 0), 1, ev, "sirene");
    end

    // Acknowledge, then return after 8 low edges in RETORNO
    passo(0, 0, 1, 0, 3, 0, 1, ev, "reconhece");
    passo(0, 1, 0, 0, 3, 0, 1, ev, "reconhecido_alto");
    passo(0, 0, 0, 0, 4, 0, 1, ev, "retorno_entra");
    for (int i = 0; i < 7; i++) passo(0, 0, 0, 0, 4, 0, 1, ev, "retorno");
    passo(0, 0, 0, 0, 0, 0, 0, ev, "retorno_fim");

    // Re-alarm from RETORNO at return count 5: no filter, phase restarts
    for (int i = 0; i < 3; i++) passo(0, 1, 0, 0, 1, 0, 0, ev, "filtro2");
    ev = 8'd2;
    passo(0, 1, 0, 0, 2, 1, 1, ev, "declara2");
    passo(0, 1, 1, 0, 3, 0, 1, ev, "reconhece2");
    passo(0, 0, 0, 0, 4, 0, 1, ev, "retorno2");
    for (int i = 0; i < 4; i++) passo(0, 0, 0, 0, 4, 0, 1, ev, "retorno2_conta");
    ev = 8'd3;
    passo(0, 1, 0, 0, 2, 1, 1, ev, "realarme");
    for (int i = 0; i < 7; i++) passo(0, 1, 0, 0, 2, 1, 1, ev, "realarme_fase");
    passo(0, 1, 0, 0, 2, 0, 1, ev, "realarme_meio");

    // teste ignored in RECONHECIDO and RETORNO
    passo(0, 1, 1, 0, 3, 0, 1, ev, "reconhece3");
    passo(0, 1, 0, 1, 3, 0, 1, ev, "teste_reconhecido");
    passo(0, 0, 0, 1, 4, 0, 1, ev, "teste_retorno");
    for (int i = 0; i < 7; i++) passo(0, 0, 0, 0, 4, 0, 1, ev, "retorno3");
    passo(0, 0, 0, 0, 0, 0, 0, ev, "normal3");

    // Test mode in NORMAL
    passo(0, 0, 0, 1, 0, 1, 1, ev, "teste_normal");
    passo(0, 0, 0, 1, 0, 1, 1, ev, "teste_mantido");
    passo(0, 0, 0, 0, 0, 0, 0, ev, "teste_fim");

    // reconhecer held across entry acknowledges on the first ALARME edge
    for (int i = 0; i < 3; i++) passo(0, 1, 1, 0, 1, 0, 0, ev, "filtro_rec");
    ev = 8'd4;
    passo(0, 1, 1, 0, 2, 1, 1, ev, "declara_rec");
    passo(0, 1, 1, 0, 3, 0, 1, ev, "reconhece_imediato");

    // Saturation: many declarations via RETORNO -> ALARME
    for (int i = 0; i < 260; i++) begin
      passo(0, 0, 0, 0, 4, 0, 1, ev, "sat_retorno");
      ev = (ev == 8'd255) ? 8'd255 : ev + 8'd1;
      passo(0, 1, 0, 0, 2, 1, 1, ev, "sat_alarme");
      passo(0, 1, 1, 0, 3, 0, 1, ev, "sat_reconhece");
    end
    passo(0, 0, 0, 0, 4, 0, 1, 8'd255, "sat_retorno_final");
    passo(0, 1, 0, 0, 2, 1, 1, 8'd255, "sat_sem_wrap");
    passo(0, 1, 0, 0, 2, 1, 1, 8'd255, "alarme_ciclo2");

    // Reset mid-ALARME with every input asserted
    passo(1, 1, 1, 1, 0, 0, 0, 0, "reset_alarme");
    passo(0, 0, 0, 0, 0, 0, 0, 0, "pos_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
